// File: rtl/sd_spi_engine_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sd_spi_engine_pkg : shared constants and state codes for the    |
// | SD SPI engine.                         Rev 1.0                  |
// +-----------------------------------------------------------------+
package sd_spi_engine_pkg;

  localparam int DIV_W = 8;

  // SCLK half-period in system clocks: 2 -> 25 MHz, 125 -> 400 kHz init rate
  localparam logic [DIV_W-1:0] HALF_FAST = 8'd2;
  localparam logic [DIV_W-1:0] HALF_SLOW = 8'd125;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_LOAD = 3'd1;
  localparam state_t S_LOW  = 3'd2;
  localparam state_t S_HIGH = 3'd3;
  localparam state_t S_NEXT = 3'd4;
  localparam state_t S_DONE = 3'd5;

endpackage
`default_nettype wire

// File: rtl/sd_clk_div.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sd_clk_div : SCLK half-period divider, one tick every i_half    |
// | clocks after a load.                   Rev 1.0                  |
// +-----------------------------------------------------------------+
module sd_clk_div
  import sd_spi_engine_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_half,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load || (r_cnt == '0)) begin
      r_cnt <= i_half - 1'b1;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A load cycle never ticks, so the first phase is always a full H long
  assign o_tick = !i_load && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/sd_spi_engine.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sd_spi_engine : SPI mode-0 byte / 12-bit word engine for an SD  |
// | card, MSB first, fast or init-rate SCLK.   Rev 1.0              |
// +-----------------------------------------------------------------+
module sd_spi_engine
  import sd_spi_engine_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        start,
  input  logic        word_mode,
  input  logic        slow,
  input  logic        cs_assert,
  input  logic [0:11] tx_data,
  output logic [0:11] rx_data,
  output logic        busy,
  output logic        done,
  output logic        sdSCLK,
  output logic        sdMOSI,
  input  logic        sdMISO,
  output logic        sdCS
);

  logic             w_rst;
  state_t           r_state;
  state_t           w_next;
  logic             w_tick;
  logic             w_div_load;
  logic             w_sclk_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic [DIV_W-1:0] r_half;
  logic [15:0]      r_tx_sr;
  logic [11:0]      r_rx_sr;
  logic [2:0]       r_bit;
  logic             r_word;
  logic             r_pend;
  logic             r_second;
  logic             r_sclk;
  logic             r_busy;
  logic             r_done;
  logic             r_cs;
  logic [11:0]      r_rx;

  assign w_rst = reset | clear;

  // Only the first byte restarts the divider; the second byte keeps its phase
  assign w_div_load = (r_state == S_LOAD) && !r_second;

  sd_clk_div u_clk_div (
    .clk    (clk),
    .rst    (w_rst),
    .i_load (w_div_load),
    .i_half (r_half),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: w_next = w_tick ? S_HIGH : S_LOW;
      S_LOW:  if (w_tick) w_next = S_HIGH;
      S_HIGH: if (w_tick) w_next = (r_bit == 3'd0) ? S_NEXT : S_LOW;
      S_NEXT: w_next = r_pend ? S_LOAD : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sclk_nxt = (w_next == S_HIGH);
    w_done_nxt = (w_next == S_DONE);
    w_busy_nxt = (w_next != S_IDLE) && (w_next != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_sclk <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_sclk <= w_sclk_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // TX shifter fills with ones so MOSI returns high on its own after the last bit
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_half   <= HALF_FAST;
      r_tx_sr  <= '1;
      r_rx_sr  <= '0;
      r_bit    <= 3'd7;
      r_word   <= 1'b0;
      r_pend   <= 1'b0;
      r_second <= 1'b0;
      r_cs     <= 1'b1;
      r_rx     <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        r_cs <= ~cs_assert;
      end
      if ((r_state == S_IDLE) && start) begin
        r_half   <= slow ? HALF_SLOW : HALF_FAST;
        r_word   <= word_mode;
        r_pend   <= word_mode;
        r_second <= 1'b0;
        r_tx_sr  <= word_mode ? {4'b0000, tx_data} : {tx_data[4:11], 8'hFF};
      end
      if (r_state == S_LOAD) begin
        r_bit <= 3'd7;
      end
      if (((r_state == S_LOAD) || (r_state == S_LOW)) && w_tick) begin
        r_rx_sr <= {r_rx_sr[10:0], sdMISO};
      end
      if ((r_state == S_HIGH) && w_tick) begin
        r_tx_sr <= {r_tx_sr[14:0], 1'b1};
        r_bit   <= r_bit - 3'd1;
      end
      if ((r_state == S_NEXT) && r_pend) begin
        r_pend   <= 1'b0;
        r_second <= 1'b1;
      end
      if (w_done_nxt) begin
        r_rx <= r_word ? r_rx_sr : {4'b0000, r_rx_sr[7:0]};
      end
    end
  end

  assign rx_data = r_rx;
  assign busy    = r_busy;
  assign done    = r_done;
  assign sdSCLK  = r_sclk;
  assign sdMOSI  = r_tx_sr[15];
  assign sdCS    = r_cs;

endmodule
`default_nettype wire
